// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for elastic pipeline stages
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // Stage payloads; instantiate a stage with WIDTH = $bits(<struct>).
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic [3:0]  alu_op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
    } id_ex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] store_data;
    } ex_mem_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] mem_data;
    } mem_wb_t;

endpackage

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - generic elastic pipeline stage with 2-entry skid buffer
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE   = '0,
    parameter bit               CLEAR_ON_EMPTY = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    pipe_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = (state_q != EMPTY) && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // A beat accepted this cycle is dropped along with the held ones.
            state_d = EMPTY;
            main_d  = BUBBLE_VALUE;
            skid_d  = BUBBLE_VALUE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        if (CLEAR_ON_EMPTY) begin
                            main_d = BUBBLE_VALUE;
                        end
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VALUE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE_VALUE;
                    skid_d  = BUBBLE_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= EMPTY;
            main_q     <= BUBBLE_VALUE;
            skid_q     <= BUBBLE_VALUE;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            // Registered from next state so no combinational ready path exists.
            in_ready_q <= (state_d != FULL);
        end
    end

    always_comb begin
        occupancy = OCC_EMPTY;
        case (state_q)
            ONE:     occupancy = OCC_ONE;
            FULL:    occupancy = OCC_FULL;
            default: occupancy = OCC_EMPTY;
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - directed self-checking bench for pipe_stage_elastic
module tb_pipe_stage_elastic;

    localparam int          W       = 32;
    localparam logic [31:0] BUBBLE1 = 32'hB0B0_0000;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;

    logic         in_ready0, out_valid0;
    logic [W-1:0] out_data0;
    logic [1:0]   occupancy0;
    logic         in_ready1, out_valid1;
    logic [W-1:0] out_data1;
    logic [1:0]   occupancy1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.WIDTH(W)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .in_data   (in_data),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_data  (out_data0),
        .occupancy (occupancy0)
    );

    pipe_stage_elastic #(.WIDTH(W), .BUBBLE_VALUE(BUBBLE1), .CLEAR_ON_EMPTY(1'b0)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_data   (in_data),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_data  (out_data1),
        .occupancy (occupancy1)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] stream [4];
        stream[0] = 32'h1; stream[1] = 32'h2; stream[2] = 32'h3; stream[3] = 32'h4;

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        check("rst_in_ready", 32'(in_ready0), 32'd1);
        check("rst_occ", 32'(occupancy0), 32'd0);
        check("rst_out_valid", 32'(out_valid0), 32'd0);
        check("rst_bubble1", out_data1, BUBBLE1);

        // 1: async reset while FULL
        in_valid = 1'b1; in_data = 32'hAAAA_AAAA;
        tick();
        check("t1_one_data", out_data0, 32'hAAAA_AAAA);
        check("t1_one_occ", 32'(occupancy0), 32'd1);
        in_data = 32'h5555_5555;
        tick();
        check("t1_full_occ", 32'(occupancy0), 32'd2);
        check("t1_full_ready", 32'(in_ready0), 32'd0);
        check("t1_full_data", out_data0, 32'hAAAA_AAAA);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("t1_async_valid", 32'(out_valid0), 32'd0);
        check("t1_async_occ", 32'(occupancy0), 32'd0);
        check("t1_async_data", out_data0, 32'h0);
        check("t1_async_data1", out_data1, BUBBLE1);
        check("t1_async_ready", 32'(in_ready0), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        check("t1_post_ready", 32'(in_ready0), 32'd1);
        check("t1_post_occ", 32'(occupancy0), 32'd0);

        // 2: streaming at one beat per cycle
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = stream[i];
            tick();
            check("t2_data", out_data0, stream[i]);
            check("t2_valid", 32'(out_valid0), 32'd1);
            check("t2_ready", 32'(in_ready0), 32'd1);
            check("t2_occ", 32'(occupancy0), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("t2_drain_valid", 32'(out_valid0), 32'd0);
        check("t2_drain_data", out_data0, 32'h0);

        // 3: backpressure fills the skid, then drains in order
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h10;
        tick();
        check("t3_first", out_data0, 32'h10);
        in_data = 32'h20;
        tick();
        check("t3_occ_full", 32'(occupancy0), 32'd2);
        check("t3_ready_low", 32'(in_ready0), 32'd0);
        check("t3_hold_a", out_data0, 32'h10);
        in_valid = 1'b0; in_data = 32'h99;
        tick();
        check("t3_hold_b", out_data0, 32'h10);
        check("t3_hold_occ", 32'(occupancy0), 32'd2);
        out_ready = 1'b1;
        tick();
        check("t3_second", out_data0, 32'h20);
        check("t3_occ_one", 32'(occupancy0), 32'd1);
        check("t3_ready_back", 32'(in_ready0), 32'd1);
        tick();
        check("t3_empty_valid", 32'(out_valid0), 32'd0);
        check("t3_empty_data", out_data0, 32'h0);
        check("t3_stale1", out_data1, 32'h20);

        // 4: flush while FULL with a beat offered
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h21;
        tick();
        in_data = 32'h22;
        tick();
        check("t4_pre_occ", 32'(occupancy0), 32'd2);
        flush = 1'b1; in_data = 32'h30;
        tick();
        check("t4_occ", 32'(occupancy0), 32'd0);
        check("t4_valid", 32'(out_valid0), 32'd0);
        check("t4_data", out_data0, 32'h0);
        check("t4_data1", out_data1, BUBBLE1);
        check("t4_ready", 32'(in_ready0), 32'd1);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("t4_no_30_valid", 32'(out_valid0), 32'd0);
        check("t4_no_30_data", out_data0, 32'h0);
        // flush in ONE drops a beat accepted in the same cycle
        in_valid = 1'b1; in_data = 32'h31;
        tick();
        flush = 1'b1; in_data = 32'h32;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("t4b_valid", 32'(out_valid0), 32'd0);
        check("t4b_data", out_data0, 32'h0);

        // 5: simultaneous in/out in ONE
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h40;
        tick();
        check("t5_main", out_data0, 32'h40);
        out_ready = 1'b1; in_data = 32'h41;
        tick();
        check("t5_next", out_data0, 32'h41);
        check("t5_occ", 32'(occupancy0), 32'd1);
        in_valid = 1'b0;
        tick();
        check("t5_drain", 32'(occupancy0), 32'd0);

        // 6: CLEAR_ON_EMPTY=0 retains stale data until flush
        in_valid = 1'b1; in_data = 32'h77;
        tick();
        check("t6_beat1", out_data1, 32'h77);
        in_valid = 1'b0;
        tick();
        check("t6_valid1", 32'(out_valid1), 32'd0);
        check("t6_stale1", out_data1, 32'h77);
        check("t6_clear0", out_data0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t6_flush1", out_data1, BUBBLE1);
        check("t6_flush_occ1", 32'(occupancy1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- One generic stage carries a WIDTH-bit packed payload of control and datapath fields.
- Uses a valid/ready handshake with a 2-entry skid buffer: full throughput, and every ready path is registered.
- Supports a dominant flush that inserts a bubble, so hazard logic can stall or flush any stage uniformly.

Parameters:
- WIDTH, 32, payload width in bits; legal range is 1 or more.
- BUBBLE_VALUE, '0, payload value held on out_data whenever the stage is empty, so RegWrite/MemWrite-style bits read as no-op.
- CLEAR_ON_EMPTY, 1, 1: main register is loaded with BUBBLE_VALUE on every transition to empty; 0: stale data is retained.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous bubble insert; dominant over all other events.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage can accept a beat; driven from a register.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  WIDTH  payload; driven directly from the main register.
- occupancy  output  2  number of held beats: 0, 1 or 2.

Behaviour:
- Beat transfers:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
- States (enum): EMPTY, ONE (main register valid), FULL (main and skid registers valid).
- Output decode:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL), registered.
  - occupancy = 0, 1 or 2 respectively.
- Reset (asserted low, any time, including mid-transfer):
  - state = EMPTY, in_ready = 1, out_valid = 0, occupancy = 0.
  - main = BUBBLE_VALUE, skid = BUBBLE_VALUE.
  - Takes effect immediately (asynchronous); the first transfer is possible on the first rising edge after deassertion.
- EMPTY:
  - Input transfer -> ONE, main <= in_data.
  - Otherwise stay in EMPTY.
- ONE:
  - Input and output transfer together -> ONE, main <= in_data (back-to-back throughput, 1 beat/cycle).
  - Input only -> FULL, skid <= in_data, in_ready falls next cycle.
  - Output only -> EMPTY; main <= BUBBLE_VALUE if CLEAR_ON_EMPTY.
  - Neither -> hold.
- FULL:
  - in_ready = 0, so no input transfer is possible.
  - Output transfer -> ONE, main <= skid, skid <= BUBBLE_VALUE.
  - Otherwise hold; out_data stays stable while out_valid && !out_ready.
- Flush (sampled at rising edge, any state):
  - Next state = EMPTY; main and skid <= BUBBLE_VALUE (regardless of CLEAR_ON_EMPTY).
  - A beat offered with in_ready = 1 in the flush cycle counts as consumed and is discarded; upstream must not replay it.
  - An output transfer in the flush cycle completes normally; downstream sees it as delivered.
- Latency and ordering:
  - Accepted beat appears on out_data the next cycle when the stage was EMPTY, or when in ONE with a simultaneous output transfer.
  - Beats leave in strict FIFO order; none is lost or duplicated except by flush.
- Invariants:
  - out_data never changes while out_valid && !out_ready.
  - occupancy never exceeds 2.
  - Payload is moved bit-exact; no width conversion.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] pipe_state_t {EMPTY, ONE, FULL}.
  - Occupancy constants OCC_EMPTY = 0, OCC_ONE = 1, OCC_FULL = 2.
  - Packed struct typedefs for each stage payload (if_id_t, id_ex_t, ex_mem_t, mem_wb_t), so the instantiation passes $bits(struct) as WIDTH.
- No sub-module; the skid register is inline.
- Chaining of stages is done by the core top level.

Test Plan:
1. Reset low mid-FULL with main = 0xAAAA_AAAA, skid = 0x5555_5555 -> same cycle: out_valid = 0, occupancy = 0, out_data = 0; after release: in_ready = 1.
2. Streaming, out_ready held 1, in_data = 1,2,3,4 on consecutive cycles -> out_data = 1,2,3,4 one cycle later, out_valid continuously high, in_ready never drops.
3. Backpressure: accept 0x10, then 0x20 with out_ready = 0 -> occupancy = 2, in_ready = 0, out_data holds 0x10; raise out_ready -> 0x10 then 0x20 delivered in order, in_ready returns to 1 after the first output transfer.
4. Flush while FULL, with a new beat 0x30 offered -> next cycle occupancy = 0, out_valid = 0, out_data = BUBBLE_VALUE; 0x30 never appears at the output.
5. Simultaneous in/out transfer in ONE (main = 0x40, in_data = 0x41, out_ready = 1) -> 0x40 delivered, out_data = 0x41 next cycle, occupancy stays 1.
6. CLEAR_ON_EMPTY = 0 build: drain the final beat 0x77 -> out_valid = 0, out_data stays 0x77; then flush -> out_data = BUBBLE_VALUE.
